// File: rtl/cp0_ctrl_if.sv
// Pipeline-to-CP0 bus: mtc0/mfc0 access, M-stage exception info, interrupts,
// and the trap/EPC results handed back to the pipeline.
interface cp0_ctrl_if;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, eret,
        input  cp0_out, req, epc_out
    );

    modport slave (
        input  en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, eret,
        output cp0_out, req, epc_out
    );
endinterface

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller: decides traps for the M stage
// and holds SR, Cause, EPC and PRId. EXL is the handler state.
module cp0_ctrl (
    input  logic        clk,
    input  logic        reset,
    cp0_ctrl_if.slave   bus
);
    localparam logic [31:0] PRID = 32'h2022_0607;

    typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} cp0State_t;

    cp0State_t   state;
    logic [5:0]  im;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  excCode;
    logic [31:0] epc;

    logic        exl;
    logic        intReq;
    logic        excReq;
    logic        trap;
    logic [31:0] srValue;
    logic [31:0] causeValue;

    assign exl    = (state == HANDLER);
    assign intReq = ie & ~exl & (|(bus.hw_int & im));
    assign excReq = ~exl & (bus.exc_code_in != 5'd0);
    // Gate with reset so the pipeline never sees a trap while CP0 is held clear.
    assign trap   = reset & (intReq | excReq);

    assign srValue    = {16'b0, im, 8'b0, exl, ie};
    assign causeValue = {bd, 15'b0, ip, 3'b0, excCode, 2'b0};

    assign bus.req     = trap;
    assign bus.epc_out = epc;

    always_comb begin
        bus.cp0_out = 32'd0;
        case (bus.cp0_addr)
            5'd12:   bus.cp0_out = srValue;
            5'd13:   bus.cp0_out = causeValue;
            5'd14:   bus.cp0_out = epc;
            5'd15:   bus.cp0_out = PRID;
            default: bus.cp0_out = 32'd0;
        endcase
    end

    // A trap takes precedence over mtc0 and eret; eret is applied after an
    // SR write so it has the final say on EXL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= NORMAL;
            im      <= 6'd0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            ip      <= 6'd0;
            excCode <= 5'd0;
            epc     <= 32'd0;
        end else begin
            ip <= bus.hw_int;
            if (trap) begin
                state   <= HANDLER;
                excCode <= intReq ? 5'd0 : bus.exc_code_in;
                bd      <= bus.bd_in;
                epc     <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
            end else begin
                if (bus.en && bus.cp0_addr == 5'd12) begin
                    im    <= bus.cp0_in[15:10];
                    state <= bus.cp0_in[1] ? HANDLER : NORMAL;
                    ie    <= bus.cp0_in[0];
                end
                if (bus.en && bus.cp0_addr == 5'd14) begin
                    epc <= bus.cp0_in;
                end
                if (bus.eret) begin
                    state <= NORMAL;
                end
            end
        end
    end
endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed self-checking bench for cp0_ctrl: reset behaviour, trap priority,
// EPC/Cause capture, mtc0/eret handling and register readback.
module tb_cp0_ctrl;
    localparam logic [31:0] PRID = 32'h2022_0607;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cp0_ctrl_if bus ();

    cp0_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [4:0] addr,
                                 input logic [31:0] din, input logic [31:0] vpc,
                                 input logic bd, input logic [4:0] code,
                                 input logic [5:0] hwInt, input logic eret);
        bus.en          = en;
        bus.cp0_addr    = addr;
        bus.cp0_in      = din;
        bus.vpc         = vpc;
        bus.bd_in       = bd;
        bus.exc_code_in = code;
        bus.hw_int      = hwInt;
        bus.eret        = eret;
        #1;
    endtask

    task automatic readReg(input logic [4:0] addr, input string tag,
                           input logic [31:0] expected);
        bus.cp0_addr = addr;
        #1;
        checkOutput(tag, bus.cp0_out, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 5'd13, 32'd0, 32'h100, 1'b0, 5'd12, 6'h3f, 1'b0);
        @(negedge clk);

        // Reset held: no trap even with interrupts and an exception pending
        applyStimulus(1'b0, 5'd13, 32'd0, 32'h100, 1'b0, 5'd12, 6'h3f, 1'b0);
        checkOutput("resetReq", {31'd0, bus.req}, 32'd0);
        readReg(5'd13, "resetCause", 32'd0);
        readReg(5'd15, "resetPrid", PRID);
        tick();
        readReg(5'd13, "resetCauseHeld", 32'd0);
        checkOutput("resetEpc", bus.epc_out, 32'd0);

        // Release: Ov exception traps with SR still zero
        reset = 1'b1;
        #1;
        checkOutput("ovReq", {31'd0, bus.req}, 32'd1);
        tick();
        readReg(5'd13, "ovCause", 32'h0000_FC30);
        readReg(5'd12, "ovSr", 32'h0000_0002);
        checkOutput("ovEpc", bus.epc_out, 32'h0000_0100);

        // mtc0 SR = 0x401 while in handler (clears EXL)
        applyStimulus(1'b1, 5'd12, 32'h0000_0401, 32'h100, 1'b0, 5'd0, 6'h00, 1'b0);
        checkOutput("mtcSrReq", {31'd0, bus.req}, 32'd0);
        tick();
        readReg(5'd12, "mtcSr", 32'h0000_0401);

        // Enabled interrupt traps
        applyStimulus(1'b0, 5'd12, 32'd0, 32'h1000, 1'b0, 5'd0, 6'h01, 1'b0);
        checkOutput("intReq", {31'd0, bus.req}, 32'd1);
        tick();
        readReg(5'd12, "intSr", 32'h0000_0403);
        readReg(5'd13, "intCause", 32'h0000_0400);
        checkOutput("intEpc", bus.epc_out, 32'h0000_1000);
        applyStimulus(1'b0, 5'd12, 32'd0, 32'h1000, 1'b0, 5'd0, 6'h01, 1'b0);
        checkOutput("intHeldReq", {31'd0, bus.req}, 32'd0);
        tick();

        // eret back to NORMAL
        applyStimulus(1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'h00, 1'b1);
        checkOutput("eretReq", {31'd0, bus.req}, 32'd0);
        tick();
        readReg(5'd12, "eretSr", 32'h0000_0401);

        // AdEL in a delay slot
        applyStimulus(1'b0, 5'd13, 32'd0, 32'h3010, 1'b1, 5'd4, 6'h00, 1'b0);
        checkOutput("adelReq", {31'd0, bus.req}, 32'd1);
        tick();
        checkOutput("adelEpc", bus.epc_out, 32'h0000_300C);
        readReg(5'd13, "adelCause", 32'h8000_0010);
        readReg(5'd12, "adelSr", 32'h0000_0403);
        applyStimulus(1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'h00, 1'b1);
        tick();
        readReg(5'd12, "adelEretSr", 32'h0000_0401);

        // Interrupt + RI + mtc0 EPC in one cycle: interrupt wins, write dropped
        applyStimulus(1'b1, 5'd14, 32'hDEAD_BEEC, 32'h2000, 1'b0, 5'd10, 6'h01, 1'b0);
        checkOutput("prioReq", {31'd0, bus.req}, 32'd1);
        tick();
        checkOutput("prioEpc", bus.epc_out, 32'h0000_2000);
        readReg(5'd13, "prioCause", 32'h0000_0400);
        readReg(5'd12, "prioSr", 32'h0000_0403);

        // Exception while EXL=1 is ignored
        applyStimulus(1'b0, 5'd13, 32'd0, 32'h5000, 1'b0, 5'd5, 6'h01, 1'b0);
        checkOutput("blockedReq", {31'd0, bus.req}, 32'd0);
        tick();
        readReg(5'd13, "blockedCause", 32'h0000_0400);
        checkOutput("blockedEpc", bus.epc_out, 32'h0000_2000);
        applyStimulus(1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'h00, 1'b1);
        tick();
        readReg(5'd12, "blockedEretSr", 32'h0000_0401);

        // Syscall at vpc 0 in a delay slot wraps EPC
        applyStimulus(1'b0, 5'd15, 32'd0, 32'd0, 1'b1, 5'd8, 6'h00, 1'b0);
        checkOutput("wrapReq", {31'd0, bus.req}, 32'd1);
        readReg(5'd15, "prid", PRID);
        readReg(5'd7, "unmapped", 32'd0);
        tick();
        checkOutput("wrapEpc", bus.epc_out, 32'hFFFF_FFFC);
        readReg(5'd13, "wrapCause", 32'h8000_0020);

        // Asynchronous reset while in the handler
        applyStimulus(1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'h00, 1'b0);
        reset = 1'b0;
        #1;
        readReg(5'd12, "asyncSr", 32'd0);
        checkOutput("asyncEpc", bus.epc_out, 32'd0);
        tick();
        reset = 1'b1;

        // mtc0 to Cause is ignored; mtc0 EPC lands on the next edge
        applyStimulus(1'b1, 5'd13, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 6'h00, 1'b0);
        checkOutput("causeWrReq", {31'd0, bus.req}, 32'd0);
        tick();
        readReg(5'd13, "causeWr", 32'd0);
        applyStimulus(1'b1, 5'd14, 32'h1234_5678, 32'd0, 1'b0, 5'd0, 6'h00, 1'b0);
        readReg(5'd14, "epcWrOld", 32'd0);
        tick();
        applyStimulus(1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'h00, 1'b0);
        checkOutput("epcWr", bus.epc_out, 32'h1234_5678);
        readReg(5'd12, "postResetSr", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
